// File: rtl/ai_traffic_controller.sv
// ai_traffic_controller
// Opponent traffic generator. Owns NUM_CARS car slots, spawns cars at the top of
// the road at a random x position with a random speed, and moves every active car
// down by its speed once per effective frame. A car is retired when it reaches
// SCREEN_BOTTOM. A shared cooldown enforces a minimum number of frames between
// spawns. Each slot is published as {img_id, x, y, width, height}, 11 bits per field.
module ai_traffic_controller #(
    parameter int NUM_CARS      = 4,
    parameter int SCREEN_BOTTOM = 480,
    parameter int SPAWN_Y       = 0,
    parameter int X_MIN         = 160,
    parameter int X_MASK        = 255,
    parameter int MIN_SPEED     = 1,
    parameter int SPAWN_GAP     = 30,
    parameter int CAR_IMG       = 1,
    parameter int CAR_W         = 32,
    parameter int CAR_H         = 36
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               frame_start,
    input  logic                               pause,
    input  logic [0:10]                        random,
    output logic [0:NUM_CARS-1][0:4][0:10]     car_states,
    output logic [0:NUM_CARS-1]                car_active
);

    localparam int CW = $clog2(SPAWN_GAP + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    // An effective frame: the only cycles in which any state may change.
    logic frame_en;
    assign frame_en = frame_start & ~pause;

    // Idle flags as of the start of this frame; slots retiring now are not eligible.
    logic [NUM_CARS-1:0] idle;
    logic [NUM_CARS-1:0] spawn_onehot;
    logic [NUM_CARS-1:0] spawn_sel;
    logic                spawn_any;

    logic [CW-1:0] cooldown_reg;
    logic [CW-1:0] cooldown_next;

    // Spawn values derived from the random word sampled in the frame_start cycle.
    logic [10:0] spawn_x;
    logic [2:0]  spawn_speed;
    assign spawn_x     = 11'(X_MIN) + (random & 11'(X_MASK));
    assign spawn_speed = 3'(MIN_SPEED) + {1'b0, random[9:10]};

    // Lowest set bit of the idle vector picks the lowest-index idle slot.
    assign spawn_onehot = idle & (~idle + {{(NUM_CARS-1){1'b0}}, 1'b1});
    assign spawn_any    = frame_en && (cooldown_reg == '0) && (|idle);
    assign spawn_sel    = spawn_any ? spawn_onehot : '0;

    // Cooldown next value: reload on spawn, otherwise count down toward zero.
    always_comb begin
        cooldown_next = cooldown_reg;
        if (frame_en) begin
            if (spawn_any) begin
                cooldown_next = CW'(SPAWN_GAP);
            end else if (cooldown_reg != '0) begin
                cooldown_next = cooldown_reg - CW'(1);
            end
        end
    end

    // Cooldown register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown_reg <= '0;
        end else begin
            cooldown_reg <= cooldown_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARS; gi++) begin : g_slot
            slot_state_t state_reg;
            slot_state_t state_next;
            logic [10:0] x_reg;
            logic [10:0] x_next;
            logic [10:0] y_reg;
            logic [10:0] y_next;
            logic [2:0]  speed_reg;
            logic [2:0]  speed_next;
            logic [11:0] y_sum;

            // 12-bit sum so reaching the bottom is detected before any 11-bit wrap.
            assign y_sum = {1'b0, y_reg} + {9'b0, speed_reg};
            assign idle[gi] = (state_reg == IDLE);

            // Slot next-state: spawn when selected, move while active, retire at the bottom.
            always_comb begin
                state_next = state_reg;
                x_next     = x_reg;
                y_next     = y_reg;
                speed_next = speed_reg;
                if (frame_en) begin
                    case (state_reg)
                        IDLE: begin
                            if (spawn_sel[gi]) begin
                                state_next = ACTIVE;
                                x_next     = spawn_x;
                                y_next     = 11'(SPAWN_Y);
                                speed_next = spawn_speed;
                            end
                        end
                        ACTIVE: begin
                            if (y_sum >= 12'(SCREEN_BOTTOM)) begin
                                state_next = IDLE;
                                y_next     = 11'(SCREEN_BOTTOM);
                            end else begin
                                y_next = y_sum[10:0];
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            // Slot registers; reset parks the car off-screen at the bottom.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    state_reg <= IDLE;
                    x_reg     <= '0;
                    y_reg     <= 11'(SCREEN_BOTTOM);
                    speed_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    speed_reg <= speed_next;
                end
            end

            // Output mapping straight from the slot registers; idle cars are not drawn.
            always_comb begin
                car_active[gi]    = (state_reg == ACTIVE);
                car_states[gi][0] = (state_reg == ACTIVE) ? 11'(CAR_IMG) : 11'd0;
                car_states[gi][1] = x_reg;
                car_states[gi][2] = (state_reg == ACTIVE) ? y_reg : 11'(SCREEN_BOTTOM);
                car_states[gi][3] = 11'(CAR_W);
                car_states[gi][4] = 11'(CAR_H);
            end
        end
    endgenerate

endmodule

// File: doc/ai_traffic_controller.md
# ai_traffic_controller

Parametrised multi-car generator for the opponent traffic on the road. It owns NUM_CARS car slots and spawns cars at the top of the road at a random x position with a random speed. Each active car advances down the screen once per frame and is retired when it passes the bottom edge. It sits between the frame timing / random source and the object drawing and collision logic, and emits one 5-field car state per slot in the codebase's standard layout: img_id, x, y, width, height, each 11 bits.

## Interface
Parameters:
- NUM_CARS, 4: number of car slots.
- SCREEN_BOTTOM, 480: y at or beyond which a car is retired.
- SPAWN_Y, 0: y of a newly spawned car.
- X_MIN, 160: left road bound for spawn x.
- X_MASK, 255: spawn x offset mask. Must be 2^k−1, and X_MIN+X_MASK+CAR_W must be ≤ the right road edge.
- MIN_SPEED, 1: minimum pixels per frame.
- SPAWN_GAP, 30: minimum number of frames between spawns.
- CAR_IMG, 1; CAR_W, 32; CAR_H, 36: constant img_id, width and height of an active car.

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse per video frame.
- pause  input  1  high means freeze all motion, spawning and cooldown.
- random  input  [0:10]  free-running random value, sampled on frame_start.
- car_states  output  [0:NUM_CARS-1][0:4][0:10]  per-slot state; field order img_id, x, y, width, height.
- car_active  output  [0:NUM_CARS-1]  slot is currently on the road.

## Operation
- Per slot: a 1-bit state machine IDLE / ACTIVE, an 11-bit y, an 11-bit x and a 3-bit speed.
- A shared cooldown counter covers SPAWN_GAP; its width is $clog2(SPAWN_GAP+1).
- All updates happen only on cycles where frame_start=1 and pause=0. Every other cycle holds all state.
- ACTIVE slot motion:
  - Compute the next y in 12 bits as y+speed.
  - If that sum is ≥ SCREEN_BOTTOM, the slot goes to IDLE and y is set to SCREEN_BOTTOM.
  - Otherwise y takes the sum. No 11-bit wrap can occur.
- Spawn:
  - Occurs when cooldown==0 and at least one slot was IDLE at the start of this frame.
  - The lowest-index such slot becomes ACTIVE.
  - It loads x=X_MIN+(random & X_MASK), y=SPAWN_Y and speed=MIN_SPEED+random[9:10].
  - cooldown is loaded with SPAWN_GAP.
- Only one spawn per frame.
- A slot that retires in the current frame is not eligible for spawn until the next frame.
- A newly spawned slot does not move in its spawn frame.
- If cooldown≠0, it decrements by 1 in that frame.
- If all slots are ACTIVE, cooldown stays 0 and the spawn is deferred to the first frame with an IDLE slot.
- Output mapping:
  - ACTIVE slot: {CAR_IMG, x, y, CAR_W, CAR_H}.
  - IDLE slot: {0, x, SCREEN_BOTTOM, CAR_W, CAR_H}. img_id 0 means "not drawn".
  - car_active[i] is 1 exactly when slot i is ACTIVE.

## Timing
- Reset (asynchronous, takes effect immediately on resetN low):
  - All slots IDLE, x=0, y=SCREEN_BOTTOM, speed=0, cooldown=0.
  - car_states = {0, 0, SCREEN_BOTTOM, CAR_W, CAR_H} for every slot.
  - car_active = 0.
- Reset during operation discards all cars and the cooldown immediately.
- Latency: outputs are registered. Updates caused by the frame_start pulse in cycle n are visible from cycle n+1 and held until the next effective frame_start.
- random is sampled only in the frame_start cycle.
- A frame_start held high for k consecutive cycles counts as k frames. No edge detection is performed; the caller must supply 1-cycle pulses.
- A pause edge takes effect in the same cycle. A frame_start with pause=1 is fully ignored.
- The first spawn happens on the first effective frame_start after reset, because cooldown=0.

## Test plan
- Reset, then 1 frame_start with random=11'h0A7, NUM_CARS=4: slot0 becomes ACTIVE with x=160+167=327, y=0, speed=1+3=4. Next cycle car_states[0]={1,327,0,32,36} and car_active=4'b1000.
- Continue with pause=0, one car only (SPAWN_GAP large): y reads 4, 8, … per frame. The frame where y=476 gives a sum of 480, so the slot goes IDLE with y=480, img_id=0, car_active[0]=0.
- SPAWN_GAP=2, frame_start every 3 cycles: spawns occur on frames 1, 4, 7 into slots 0, 1, 2. There is no spawn on frames 2–3 or 5–6.
- All 4 slots ACTIVE with cooldown expired: no spawn. When slot 2 retires in frame F, the spawn goes to slot 2 in frame F+1, not in frame F.
- pause=1 across 10 frame_start pulses: car_states, car_active and cooldown stay unchanged. Releasing pause resumes motion from the same y.
- resetN pulsed low mid-frame with 3 cars active: all outputs return to reset values asynchronously in the same cycle, and the first frame after reset spawns into slot 0.
